mux151_poll_arbiter: RTL and testbench
======================================

Name: mux151_poll_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 mux (74x151 emulation model) among 8 request lines. The request lines are wired to the mux data inputs D0..D7.
- The block drives the mux select and strobe, waits a programmable settle time, then samples Y/W. It grants the first requester found and holds the grant until `done` or timeout.
- It sits in the FPGA emulation next to the ic74x151 instance. It replaces hand-wired select sequencing for interrupt/condition polling.

Parameters:
- `SETTLE_CYCLES`, default 2: idle cycles between a select change and the sample. Legal range 0..15.
- `TIMEOUT_CYCLES`, default 255: maximum grant hold in cycles. 0 disables the timeout. Legal range 0..65535.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  polling enable.
- `mux_sel`  out  3  select to the mux. Bit 2 drives the MSB select pin, bit 0 the LSB pin.
- `mux_strobe`  out  1  to the mux strobe pin. 1 forces Y=1 in the emulation model; 0 passes data.
- `mux_y`  in  1  mux Y output.
- `mux_w`  in  1  mux W output; must equal ~Y.
- `grant`  out  1  a requester is granted.
- `grant_id`  out  3  index of the granted requester; valid while `grant`=1.
- `done`  in  1  single-cycle pulse from the granted user releasing the grant.
- `error`  out  1  sticky flag: Y==W seen at a sample.
- `timeout`  out  1  one-cycle pulse: grant revoked by timeout.

Behaviour:
Reset (`rst`=1 at an edge):
- `mux_sel`=0, `mux_strobe`=1, `grant`=0, `grant_id`=0, `error`=0, `timeout`=0.
- Round-robin pointer = 0, state = IDLE. Reset overrides everything, including mid-GRANT (grant drops on the next edge).

States: IDLE, SETTLE, SAMPLE, GRANT.

IDLE:
- `mux_strobe`=1.
- If `enable`=1: `mux_sel`<=pointer, `mux_strobe`<=0, settle counter <= `SETTLE_CYCLES`, go to SETTLE.

SETTLE:
- Counter nonzero: decrement.
- Counter zero: go to SAMPLE.
- SETTLE lasts `SETTLE_CYCLES`+1 cycles.

SAMPLE (uses `mux_y`/`mux_w` from this cycle):
- If `mux_y`==`mux_w`: set `error` (sticky until `rst`) and treat as no request.
- Valid Y=1: `grant`<=1, `grant_id`<=`mux_sel`, `mux_strobe`<=1, timeout counter <= `TIMEOUT_CYCLES`, go to GRANT.
- No request and `enable`=1: `mux_sel`<=`mux_sel`+1 (wraps 7->0), reload settle counter, go to SETTLE.
- No request and `enable`=0: `mux_strobe`<=1, pointer <= `mux_sel`+1 (wrap), go to IDLE.

GRANT:
- Outputs held.
- Timeout counter decrements each cycle when `TIMEOUT_CYCLES`!=0.
- Release occurs on `done`=1, or when the counter reaches 0 with `TIMEOUT_CYCLES`!=0. On release:
  - `grant`<=0 and pointer <= `grant_id`+1 (wrap).
  - On timeout release, additionally `timeout`<=1 for exactly one cycle.
  - If `enable`=1: `mux_sel`<=new pointer, `mux_strobe`<=0, go to SETTLE. Otherwise go to IDLE.
- `done` and timeout in the same cycle: treat as `done`; no timeout pulse.
- `done` outside GRANT is ignored.
- `enable` deassert during GRANT does not revoke the grant.

Timing:
- Per-channel poll period = `SETTLE_CYCLES`+2 cycles.
- Grant is visible `SETTLE_CYCLES`+2 cycles after `mux_sel` changes to the requester.
- Worst-case grant latency = 8*(`SETTLE_CYCLES`+2).
- Fairness: after a grant to k, polling resumes at k+1. No requester waits more than 7 other grants.

Arithmetic:
- `mux_sel`/pointer are 3-bit modulo-8.
- Settle counter is 4 bits; timeout counter is 16 bits.

Decomposition:
- Package mux151_arb_pkg: state enum (IDLE, SETTLE, SAMPLE, GRANT), `SEL_W`=3, `N_SRC`=8.
- One sub-module, arb_down_counter: loadable down-counter with a zero flag, parameterised width. Instantiated twice, 4-bit for settle and 16-bit for timeout.
- The top module holds the FSM and pointer.

Test Plan:
- Reset and idle: `rst`=1 then `enable`=0 for 20 cycles -> `mux_strobe`=1, `mux_sel`=0, `grant`=0, `error`=0 throughout.
- Single request: D5=1 only, `enable`=1, `SETTLE_CYCLES`=2 -> `mux_sel` steps 0..5 every 4 cycles. `grant`=1 with `grant_id`=5 at cycle 6*4=24 after enable. `done` pulse -> `grant`=0 next cycle, `mux_sel`=6.
- Round-robin: D1, D3 and D6 held high, `done` pulsed 3 cycles after each grant -> `grant_id` sequence 1,3,6,1,3,6.
- Timeout: `TIMEOUT_CYCLES`=10, D2=1, no `done` -> `grant` held 10 cycles, one-cycle `timeout` pulse, then polling resumes at `mux_sel`=3.
- `done`/timeout collision and enable drop: `done` on the exact timeout cycle -> no `timeout` pulse. With `enable`=0 during GRANT -> IDLE, `mux_strobe`=1 after release.
- Fault: force `mux_w`=`mux_y`=1 on channel 4 -> `error`=1 sticky, no grant to 4, scan continues to 5. `rst` clears `error`.

Source files
------------

// File: rtl/mux151_arb_pkg.sv
// Shared types and constants for the 74x151 polling arbiter.
// State encoding, select width and source count are shared by the top and the bench.
package mux151_arb_pkg;

  localparam int SEL_W = 3;
  localparam int N_SRC = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_GRANT  = 2'd3
  } arb_state_e;

  // Modulo-8 successor of a select value or pointer.
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
    return s + 3'd1;
  endfunction

endpackage

// File: rtl/arb_down_counter.sv
// Loadable down-counter that saturates at zero and flags zero.
// Load takes priority over decrement.
module arb_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Count register: reset, load, or decrement toward zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end else begin
      count_q <= count_q;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mux151_poll_arbiter.sv
// Round-robin arbiter polling 8 request lines through one 74x151 mux.
// Steps the select, waits for the mux to settle, samples Y/W and holds a grant.
module mux151_poll_arbiter
  import mux151_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic [SEL_W-1:0] mux_sel,
  output logic             mux_strobe,
  input  logic             mux_y,
  input  logic             mux_w,
  output logic             grant,
  output logic [SEL_W-1:0] grant_id,
  input  logic             done,
  output logic             error,
  output logic             timeout
);

  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYCLES);
  localparam bit          TO_EN     = (TIMEOUT_CYCLES != 0);
  // Loaded with N-1 so that the zero flag marks the last of N hold cycles.
  localparam logic [15:0] TO_LD     = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] id_q;
  logic             strobe_q;
  logic             grant_q;
  logic             error_q;
  logic             timeout_q;

  logic [SEL_W-1:0] sel_inc_d;
  logic [SEL_W-1:0] rel_ptr_d;
  logic             sample_bad_s;
  logic             req_valid_s;
  logic             to_hit_s;
  logic             release_s;
  logic             settle_load_s;
  logic             settle_dec_s;
  logic             settle_zero_s;
  logic             to_load_s;
  logic             to_dec_s;
  logic             to_zero_s;

  // Sample decode, release detection and counter control strobes.
  always_comb begin
    sel_inc_d     = sel_next(sel_q);
    rel_ptr_d     = sel_next(id_q);
    sample_bad_s  = (mux_y == mux_w);
    req_valid_s   = ~sample_bad_s & mux_y;
    to_hit_s      = TO_EN & to_zero_s;
    release_s     = done | to_hit_s;
    settle_load_s = 1'b0;
    settle_dec_s  = 1'b0;
    to_load_s     = 1'b0;
    to_dec_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        settle_load_s = enable;
      end
      ST_SETTLE: begin
        settle_dec_s = 1'b1;
      end
      ST_SAMPLE: begin
        if (req_valid_s) begin
          to_load_s = 1'b1;
        end else begin
          settle_load_s = enable;
        end
      end
      ST_GRANT: begin
        to_dec_s      = TO_EN;
        settle_load_s = release_s & enable;
      end
      default: begin
        settle_load_s = 1'b0;
      end
    endcase
  end

  arb_down_counter #(.WIDTH(4)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (settle_load_s),
    .load_val (SETTLE_LD),
    .dec      (settle_dec_s),
    .zero     (settle_zero_s)
  );

  arb_down_counter #(.WIDTH(16)) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load_s),
    .load_val (TO_LD),
    .dec      (to_dec_s),
    .zero     (to_zero_s)
  );

  // Polling FSM with pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 3'd0;
      sel_q     <= 3'd0;
      id_q      <= 3'd0;
      strobe_q  <= 1'b1;
      grant_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          strobe_q <= 1'b1;
          if (enable) begin
            sel_q    <= ptr_q;
            strobe_q <= 1'b0;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_zero_s) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (sample_bad_s) begin
            error_q <= 1'b1;
          end
          if (req_valid_s) begin
            grant_q  <= 1'b1;
            id_q     <= sel_q;
            strobe_q <= 1'b1;
            state_q  <= ST_GRANT;
          end else if (enable) begin
            sel_q   <= sel_inc_d;
            state_q <= ST_SETTLE;
          end else begin
            strobe_q <= 1'b1;
            ptr_q    <= sel_inc_d;
            state_q  <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            grant_q   <= 1'b0;
            ptr_q     <= rel_ptr_d;
            timeout_q <= ~done;
            if (enable) begin
              sel_q    <= rel_ptr_d;
              strobe_q <= 1'b0;
              state_q  <= ST_SETTLE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mux_sel    = sel_q;
  assign mux_strobe = strobe_q;
  assign grant      = grant_q;
  assign grant_id   = id_q;
  assign error      = error_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_mux151_poll_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// poll-window reference model of the arbiter and a 74x151 behavioural mux.
module tb_mux151_poll_arbiter;

  localparam int S = 2;
  localparam int T = 10;

  logic       clk = 1'b0;
  logic       rst, enable, done;
  logic [2:0] mux_sel, grant_id;
  logic       mux_strobe, mux_y, mux_w, grant, error, timeout;
  logic [7:0] req;
  logic       fault_en;
  logic [2:0] fault_ch;
  logic       hit_s;

  always #5 clk = ~clk;

  // 74x151 emulation: strobe forces Y=1; a fault on a channel forces Y=W=1.
  assign hit_s = fault_en && (mux_sel == fault_ch);
  assign mux_y = mux_strobe ? 1'b1 : (hit_s ? 1'b1 : req[mux_sel]);
  assign mux_w = hit_s ? mux_y : ~mux_y;

  mux151_poll_arbiter #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mux_sel    (mux_sel),
    .mux_strobe (mux_strobe),
    .mux_y      (mux_y),
    .mux_w      (mux_w),
    .grant      (grant),
    .grant_id   (grant_id),
    .done       (done),
    .error      (error),
    .timeout    (timeout)
  );

  // Reference model: mode 0 idle, 1 polling (phase = cycles into window), 2 granted.
  int         m_mode, m_phase, m_hold;
  logic [2:0] m_sel, m_ptr, m_id;
  logic       m_strobe, m_grant, m_err, m_to;

  int n_checks = 0;
  int n_fail   = 0;
  int done_at  = -1;
  bit stray    = 1'b0;
  bit rand_mode = 1'b0;
  bit prev_grant = 1'b0;
  int to_pulses = 0;
  logic [2:0] gseq[$];

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic y, w;
    bit   hit;
    m_to = 1'b0;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_hold = 0;
      m_sel = 3'd0; m_ptr = 3'd0; m_id = 3'd0;
      m_strobe = 1'b1; m_grant = 1'b0; m_err = 1'b0;
      return;
    end
    case (m_mode)
      0: if (enable) begin
        m_sel = m_ptr; m_strobe = 1'b0; m_mode = 1; m_phase = 0;
      end
      1: if (m_phase < S + 1) begin
        m_phase++;
      end else begin
        hit = fault_en && (m_sel == fault_ch);
        y = hit ? 1'b1 : req[m_sel];
        w = hit ? 1'b1 : ~y;
        if (y == w) m_err = 1'b1;
        if (y != w && y) begin
          m_grant = 1'b1; m_id = m_sel; m_strobe = 1'b1; m_mode = 2; m_hold = 0;
        end else if (enable) begin
          m_sel = m_sel + 3'd1; m_phase = 0;
        end else begin
          m_strobe = 1'b1; m_ptr = m_sel + 3'd1; m_mode = 0;
        end
      end
      2: if (done || (T != 0 && m_hold + 1 == T)) begin
        m_grant = 1'b0; m_ptr = m_id + 3'd1; m_to = !done;
        if (enable) begin
          m_sel = m_ptr; m_strobe = 1'b0; m_mode = 1; m_phase = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_hold++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_outputs();
    check_eq("mux_sel", 16'(mux_sel), 16'(m_sel));
    check_eq("mux_strobe", 16'(mux_strobe), 16'(m_strobe));
    check_eq("grant", 16'(grant), 16'(m_grant));
    check_eq("error", 16'(error), 16'(m_err));
    check_eq("timeout", 16'(timeout), 16'(m_to));
    if (m_grant) check_eq("grant_id", 16'(grant_id), 16'(m_id));
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_mode) begin
        rst    = ($urandom_range(0, 299) == 0);
        enable = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) req = 8'($urandom);
        if ($urandom_range(0, 99) == 0) fault_en = ~fault_en;
        if ($urandom_range(0, 49) == 0) fault_ch = 3'($urandom);
      end
      if (m_mode == 2)
        done = (done_at >= 0 && m_hold == done_at) || (rand_mode && $urandom_range(0, 5) == 0);
      else
        done = stray && ($urandom_range(0, 3) == 0);
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_outputs();
      if (timeout) to_pulses++;
      if (grant && !prev_grant) gseq.push_back(grant_id);
      prev_grant = grant;
    end
  endtask

  task automatic wait_grant(input string tag, output int cycles);
    cycles = 0;
    while (!grant && cycles < 200) begin
      run_cycles(1);
      cycles++;
    end
    if (!grant) check_eq({tag, "_wait"}, 16'(cycles), 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; done = 1'b0;
    run_cycles(2);
    rst = 1'b0;
  endtask

  int lat;

  initial begin
    rst = 1'b1; enable = 1'b0; done = 1'b0; req = 8'h00;
    fault_en = 1'b0; fault_ch = 3'd0;

    // Reset and idle.
    do_reset();
    run_cycles(20);

    // Single request on D5; grant 25 edges after the enabling edge is counted as 1.
    req = 8'h20; enable = 1'b1; done_at = 2;
    wait_grant("d5", lat);
    check_eq("d5_latency", 16'(lat), 16'(6 * (S + 2) + 1));
    check_eq("d5_id", 16'(grant_id), 16'd5);
    run_cycles(3);
    check_eq("d5_release", 16'(grant), 16'd0);
    check_eq("d5_sel_after", 16'(mux_sel), 16'd6);

    // Round-robin among D1, D3, D6.
    do_reset();
    gseq.delete();
    req = 8'h4A; enable = 1'b1; stray = 1'b1;
    run_cycles(140);
    check_eq("rr_count_min", 16'(gseq.size() >= 6), 16'd1);
    begin
      logic [2:0] exp_rr[6];
      exp_rr = '{3'd1, 3'd3, 3'd6, 3'd1, 3'd3, 3'd6};
      for (int k = 0; k < 6 && k < gseq.size(); k++)
        check_eq("rr_seq", 16'(gseq[k]), 16'(exp_rr[k]));
    end
    stray = 1'b0;

    // Timeout on D2 with no done.
    do_reset();
    req = 8'h04; enable = 1'b1; done_at = -1; to_pulses = 0;
    wait_grant("to", lat);
    run_cycles(T);
    check_eq("to_grant_drop", 16'(grant), 16'd0);
    check_eq("to_pulse_seen", 16'(timeout), 16'd1);
    check_eq("to_resume_sel", 16'(mux_sel), 16'd3);
    run_cycles(1);
    check_eq("to_pulse_once", 16'(timeout), 16'd0);

    // done on the exact timeout cycle: no timeout pulse.
    do_reset();
    req = 8'h04; done_at = T - 1; to_pulses = 0; enable = 1'b1;
    wait_grant("col", lat);
    run_cycles(T + 2);
    check_eq("col_no_pulse", 16'(to_pulses), 16'd0);

    // Enable dropped during grant: release goes to idle.
    do_reset();
    req = 8'h08; done_at = 4; enable = 1'b1;
    wait_grant("en", lat);
    enable = 1'b0;
    run_cycles(10);
    check_eq("en_idle_strobe", 16'(mux_strobe), 16'd1);
    check_eq("en_idle_grant", 16'(grant), 16'd0);

    // Fault on channel 4: sticky error, scan continues to 5, reset clears.
    do_reset();
    gseq.delete();
    req = 8'h30; fault_en = 1'b1; fault_ch = 3'd4; done_at = 1; enable = 1'b1;
    wait_grant("flt", lat);
    check_eq("flt_id", 16'(grant_id), 16'd5);
    check_eq("flt_error", 16'(error), 16'd1);
    run_cycles(30);
    check_eq("flt_sticky", 16'(error), 16'd1);
    do_reset();
    check_eq("flt_cleared", 16'(error), 16'd0);
    fault_en = 1'b0;

    // Random traffic.
    done_at = -1; stray = 1'b1; rand_mode = 1'b1;
    run_cycles(3000);
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
